// File: rtl/fixed_mul_arbiter.sv
// rtl/fixed_mul_arbiter.sv - round-robin arbiter sharing one pipelined saturating Q(D.Q) multiplier
// Requester tags ride alongside the product so each result pulses back to its issuer.
module fixed_mul_arbiter #(
  parameter int N   = 4,
  parameter int D   = 8,
  parameter int Q   = 24,
  parameter int LAT = 7,
  parameter int CW  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N-1:0]       req_valid,
  input  logic [N*(D+Q)-1:0] req_a,
  input  logic [N*(D+Q)-1:0] req_b,
  output logic [N-1:0]       req_ready,
  output logic [N-1:0]       resp_valid,
  output logic [D+Q-1:0]     resp_r,
  output logic               busy,
  output logic [CW-1:0]      issue_count
);

  localparam int W  = D + Q;
  localparam int TW = (N > 1) ? $clog2(N) : 1;

  logic [TW-1:0]         r_ptr;
  logic                  w_accept;
  logic [TW-1:0]         w_gnt;
  logic [LAT-1:0]        r_vld;
  logic [TW-1:0]         r_tag [0:LAT-1];
  logic signed [W-1:0]   r_a;
  logic signed [W-1:0]   r_b;
  logic signed [2*W-1:0] r_prod;
  logic [W-1:0]          r_sat [2:LAT-1];
  logic                  r_busy;
  logic [N-1:0]          r_resp_valid;
  logic [W-1:0]          r_resp_r;
  logic [CW-1:0]         r_count;

  // Arithmetic shift floors toward -inf; saturate whenever the bits above the sign differ.
  function automatic logic [W-1:0] f_sat(input logic signed [2*W-1:0] p);
    logic signed [2*W-1:0] s;
    s = p >>> Q;
    if (s[2*W-1:W-1] == '0 || s[2*W-1:W-1] == '1)
      return s[W-1:0];
    else if (s[2*W-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  // Later iterations overwrite earlier ones, so the smallest offset from r_ptr wins.
  always_comb begin
    int          idx;
    logic [TW-1:0] sel;
    w_accept = 1'b0;
    w_gnt    = '0;
    idx      = 0;
    sel      = '0;
    if (en && rst_n) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) idx = idx - N;
        sel = TW'(idx);
        if (req_valid[sel]) begin
          w_accept = 1'b1;
          w_gnt    = sel;
        end
      end
    end
  end

  assign req_ready = w_accept ? ({{(N-1){1'b0}}, 1'b1} << w_gnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_vld        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_prod       <= '0;
      r_busy       <= 1'b0;
      r_resp_valid <= '0;
      r_resp_r     <= '0;
      r_count      <= '0;
      for (int k = 0; k < LAT; k++) r_tag[k] <= '0;
      for (int k = 2; k < LAT; k++) r_sat[k] <= '0;
    end else begin
      r_vld    <= {r_vld[LAT-2:0], w_accept};
      r_tag[0] <= w_gnt;
      for (int k = 1; k < LAT; k++) r_tag[k] <= r_tag[k-1];

      if (w_accept) begin
        r_a     <= req_a[int'(w_gnt)*W +: W];
        r_b     <= req_b[int'(w_gnt)*W +: W];
        r_ptr   <= (w_gnt == TW'(N - 1)) ? '0 : w_gnt + 1'b1;
        r_count <= r_count + 1'b1;
      end

      r_prod   <= r_a * r_b;
      r_sat[2] <= f_sat(r_prod);
      for (int k = 3; k < LAT; k++) r_sat[k] <= r_sat[k-1];

      r_busy       <= |{r_vld[LAT-2:0], w_accept};
      r_resp_valid <= r_vld[LAT-1] ? ({{(N-1){1'b0}}, 1'b1} << r_tag[LAT-1]) : '0;
      if (r_vld[LAT-1]) r_resp_r <= r_sat[LAT-1];
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_r      = r_resp_r;
  assign busy        = r_busy;
  assign issue_count = r_count;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// tb/tb_fixed_mul_arbiter.sv - directed self-checking bench for fixed_mul_arbiter
module tb_fixed_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 7;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_r;
  logic           busy;
  logic [CW-1:0]  issue_count;

  int tests = 0;
  int fails = 0;

  fixed_mul_arbiter #(.N(N), .D(8), .Q(24), .LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_r(resp_r),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
  endtask

  // Issue one operation from a single requester and check its response lands exactly LAT edges later.
  task automatic run_op(input string tag, input int idx, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    set_op(idx, a, b);
    req_valid = N'(1) << idx;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(N'(1) << idx));
    tick();
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) chk({tag, "_early"}, 64'(resp_valid), 64'd0);
    end
    chk({tag, "_rv"}, 64'(resp_valid), 64'(N'(1) << idx));
    chk({tag, "_r"}, 64'(resp_r), 64'(exp));
  endtask

  initial begin
    logic [W-1:0] exp_r;
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #12;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rv", 64'(resp_valid), 64'd0);
    chk("rst_r", 64'(resp_r), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(issue_count), 64'd0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // Single issue with full latency/busy profile
    set_op(1, 32'h0100_0000, 32'h0200_0000);
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    chk("single_cnt", 64'(issue_count), 64'd1);
    for (int k = 1; k < LAT; k++) begin
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_quiet", 64'(resp_valid), 64'd0);
      tick();
    end
    chk("single_busy_last", 64'(busy), 64'd1);
    tick();
    chk("single_rv", 64'(resp_valid), 64'h2);
    chk("single_r", 64'(resp_r), 64'h0200_0000);
    chk("single_idle", 64'(busy), 64'd0);
    tick();
    chk("single_pulse", 64'(resp_valid), 64'd0);
    chk("single_hold", 64'(resp_r), 64'h0200_0000);

    // Saturation and negative results
    run_op("sat_pos", 0, 32'h6400_0000, 32'h6400_0000, 32'h7FFF_FFFF);
    run_op("sat_neg", 0, 32'h6400_0000, 32'h9C00_0000, 32'h8000_0000);
    run_op("neg", 0, 32'hFE80_0000, 32'h0200_0000, 32'hFD00_0000);
    run_op("floor", 0, 32'hFFFF_FFFF, 32'h0080_0000, 32'hFFFF_FFFF);

    // Pointer skip: run_op on requester 1 leaves ptr=2
    run_op("to_ptr2", 1, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    req_valid = 4'b0001;
    #1;
    chk("skip_g0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("skip_g3", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    for (int k = 0; k < LAT + 1; k++) tick();
    chk("skip_cnt", 64'(issue_count), 64'd8);

    // Round-robin with all four requesting (ptr is 0 here)
    for (int i = 0; i < N; i++) set_op(i, 32'((i + 1) << 24), 32'h0180_0000);
    for (int c = 0; c < 15; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_ready", 64'(req_ready), (c < 8) ? 64'(N'(1) << (c % 4)) : 64'd0);
      tick();
      if (c >= LAT) begin
        exp_r = 32'(((c - LAT) % 4 + 1) * 32'h0180_0000);
        chk("rr_rv", 64'(resp_valid), 64'(N'(1) << ((c - LAT) % 4)));
        chk("rr_r", 64'(resp_r), 64'(exp_r));
      end else begin
        chk("rr_quiet", 64'(resp_valid), 64'd0);
      end
    end
    chk("rr_cnt", 64'(issue_count), 64'd16);

    // en gating: three issues, then en low with requests pending
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        en = 1'b1;
        req_valid = 4'b0111;
        set_op(c, 32'((c + 2) << 24), 32'h0040_0000);
      end else begin
        en = 1'b0;
        req_valid = 4'b1111;
      end
      #1;
      chk("en_ready", 64'(req_ready), (c < 3) ? 64'(N'(1) << c) : 64'd0);
      tick();
      if (c >= LAT) begin
        exp_r = 32'((c - LAT + 2) * 32'h0040_0000);
        chk("en_rv", 64'(resp_valid), 64'(N'(1) << (c - LAT)));
        chk("en_r", 64'(resp_r), 64'(exp_r));
      end
    end
    en = 1'b1;
    #1;
    chk("en_ptr_held", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    chk("en_cnt", 64'(issue_count), 64'd20);
    for (int k = 0; k < LAT + 1; k++) tick();

    // Async reset mid-flight
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rv", 64'(resp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cnt", 64'(issue_count), 64'd0);
    chk("arst_r", 64'(resp_r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      chk("arst_no_pulse", 64'(resp_valid), 64'd0);
    end
    chk("arst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
